// File: rtl/mezclador_ecualizador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mezclador_ecualizador_pkg
// Purpose  : Shared constants and types for the per-band gain/mix stage.
//            Fixed-point format is Q(MAGNITUD).(DECIMAL) plus a sign bit.
//            Build option MEZCLA_SATURACION_EN is consumed by saturador_q.
// Contents : MAGNITUD, DECIMAL, N, ACC_W, UNO, SAT_MAX, SAT_MIN, estado_t
// Revision : 1.0 - initial release
// ============================================================================
package mezclador_ecualizador_pkg;

  localparam int MAGNITUD = 8;
  localparam int DECIMAL  = 14;
  localparam int N        = MAGNITUD + DECIMAL + 1;
  // Two guard bits: three full-scale products cannot overflow the sum.
  localparam int ACC_W    = 2 * N + 2;

  localparam logic        [N-1:0] UNO     = N'(1) << DECIMAL;
  localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC_B = 3'd1,
    MAC_M = 3'd2,
    MAC_A = 3'd3,
    SAT   = 3'd4
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/saturador_q.sv
`default_nettype none
// ============================================================================
// Module   : saturador_q
// Purpose  : Combinational rescale of the wide accumulator back to the Q
//            format: arithmetic shift right by DECIMAL (floor, no rounding)
//            followed by a clamp to [SAT_MIN, SAT_MAX].
//            Macro MEZCLA_SATURACION_EN: when undefined the clamp is removed
//            and the result is the low N bits of the shifted value (wraps).
// Ports    : acc_i  [ACC_W-1:0]  signed accumulator
//            dato_o [N-1:0]      signed result in Q format
// Revision : 1.0 - initial release
// ============================================================================
module saturador_q
  import mezclador_ecualizador_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  output logic [N-1:0]     dato_o
);

  logic signed [ACC_W-1:0] w_desplazado;

  assign w_desplazado = $signed(acc_i) >>> DECIMAL;

`ifdef MEZCLA_SATURACION_EN
  // Limits sign-extended to the accumulator width for a signed compare.
  localparam logic signed [ACC_W-1:0] LIM_MAX = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LIM_MIN = ACC_W'(SAT_MIN);

  always_comb begin
    dato_o = w_desplazado[N-1:0];
    if (w_desplazado > LIM_MAX) begin
      dato_o = SAT_MAX;
    end else if (w_desplazado < LIM_MIN) begin
      dato_o = SAT_MIN;
    end
  end
`else
  assign dato_o = w_desplazado[N-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/mezclador_ecualizador.sv
`default_nettype none
// ============================================================================
// Module   : mezclador_ecualizador
// Purpose  : Multiplies the low/mid/high band samples by their gains, sums
//            the three products and rescales to Q format. One shared
//            multiplier is sequenced by a five-state FSM; latency is 4 clocks
//            from the accepted enable to valid_out.
//            Macro MEZCLA_SATURACION_EN selects clamping (defined) or
//            two's-complement wrap (undefined) of the final result.
// Ports    : clk, reset (sync, active-high), enable (sample strobe)
//            Data_In_bajos/medios/altos [N-1:0] band samples
//            gain_bajos/medios/altos    [N-1:0] band gains
//            Data_Out [N-1:0], valid_out (1-cycle pulse), overrun (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module mezclador_ecualizador
  import mezclador_ecualizador_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] Data_In_bajos,
  input  logic [N-1:0] Data_In_medios,
  input  logic [N-1:0] Data_In_altos,
  input  logic [N-1:0] gain_bajos,
  input  logic [N-1:0] gain_medios,
  input  logic [N-1:0] gain_altos,
  output logic [N-1:0] Data_Out,
  output logic         valid_out,
  output logic         overrun
);

  estado_t            estado_q, estado_d;
  logic [N-1:0]       dato_b_q, dato_b_d, dato_m_q, dato_m_d, dato_a_q, dato_a_d;
  logic [N-1:0]       gan_b_q, gan_b_d, gan_m_q, gan_m_d, gan_a_q, gan_a_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [N-1:0]       data_out_q, data_out_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic signed [N-1:0]     w_op_dato, w_op_gan;
  logic signed [2*N-1:0]   w_prod;
  logic        [ACC_W-1:0] w_prod_ext;
  logic        [N-1:0]     w_sat;

  // Operand mux for the shared multiplier; kept apart from the FSM block so
  // the product feeds the accumulator without a combinational self-loop.
  always_comb begin
    w_op_dato = dato_b_q;
    w_op_gan  = gan_b_q;
    case (estado_q)
      MAC_M: begin
        w_op_dato = dato_m_q;
        w_op_gan  = gan_m_q;
      end
      MAC_A: begin
        w_op_dato = dato_a_q;
        w_op_gan  = gan_a_q;
      end
      default: begin
        w_op_dato = dato_b_q;
        w_op_gan  = gan_b_q;
      end
    endcase
  end

  assign w_prod     = w_op_dato * w_op_gan;
  assign w_prod_ext = {{(ACC_W-2*N){w_prod[2*N-1]}}, w_prod};

  saturador_q u_saturador (
    .acc_i  (acc_q),
    .dato_o (w_sat)
  );

  always_comb begin
    estado_d   = estado_q;
    dato_b_d   = dato_b_q;
    dato_m_d   = dato_m_q;
    dato_a_d   = dato_a_q;
    gan_b_d    = gan_b_q;
    gan_m_d    = gan_m_q;
    gan_a_d    = gan_a_q;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    // Any strobe outside IDLE is dropped and flagged until reset.
    overrun_d  = overrun_q | (enable & (estado_q != IDLE));

    case (estado_q)
      IDLE: begin
        if (enable) begin
          dato_b_d = Data_In_bajos;
          dato_m_d = Data_In_medios;
          dato_a_d = Data_In_altos;
          gan_b_d  = gain_bajos;
          gan_m_d  = gain_medios;
          gan_a_d  = gain_altos;
          estado_d = MAC_B;
        end
      end
      MAC_B: begin
        acc_d    = w_prod_ext;
        estado_d = MAC_M;
      end
      MAC_M: begin
        acc_d    = acc_q + w_prod_ext;
        estado_d = MAC_A;
      end
      MAC_A: begin
        acc_d    = acc_q + w_prod_ext;
        estado_d = SAT;
      end
      SAT: begin
        data_out_d = w_sat;
        valid_d    = 1'b1;
        estado_d   = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= IDLE;
      dato_b_q   <= '0;
      dato_m_q   <= '0;
      dato_a_q   <= '0;
      gan_b_q    <= '0;
      gan_m_q    <= '0;
      gan_a_q    <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      dato_b_q   <= dato_b_d;
      dato_m_q   <= dato_m_d;
      dato_a_q   <= dato_a_d;
      gan_b_q    <= gan_b_d;
      gan_m_q    <= gan_m_d;
      gan_a_q    <= gan_a_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign Data_Out  = data_out_q;
  assign valid_out = valid_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire
